// File: rtl/ulpb_host_if_if.sv
// Node-side message bus of the ulpb host companion: TX and RX
// request/acknowledge pairs plus the bus-level acknowledge level.
interface ulpb_host_if_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ADDR_IN;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  REQ_TX;
  logic                  ACK_TX;
  logic [ADDR_WIDTH-1:0] ADDR_OUT;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  REQ_RX;
  logic                  ACK_RX;
  logic                  ACK_RECEIVED;

  modport master (
    output ADDR_IN,
    output DATA_IN,
    output REQ_TX,
    input  ACK_TX,
    input  ADDR_OUT,
    input  DATA_OUT,
    input  REQ_RX,
    output ACK_RX,
    input  ACK_RECEIVED
  );

  modport slave (
    input  ADDR_IN,
    input  DATA_IN,
    input  REQ_TX,
    output ACK_TX,
    output ADDR_OUT,
    output DATA_OUT,
    output REQ_RX,
    input  ACK_RX,
    output ACK_RECEIVED
  );
endinterface

// File: rtl/ulpb_host_if.sv
// Host companion for the ulpb node: TX/RX message queues, four-phase
// handshakes towards the node and a bus acknowledge counter.
module ulpb_host_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TX_WR_EN,
  input  logic [ADDR_WIDTH-1:0] TX_WR_ADDR,
  input  logic [DATA_WIDTH-1:0] TX_WR_DATA,
  output logic                  TX_FULL,
  output logic                  TX_BUSY,
  input  logic                  RX_RD_EN,
  output logic [ADDR_WIDTH-1:0] RX_RD_ADDR,
  output logic [DATA_WIDTH-1:0] RX_RD_DATA,
  output logic                  RX_EMPTY,
  output logic [7:0]            ACK_CNT,
  ulpb_host_if_if.master        node
);

  localparam int MW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;

  localparam logic [TCW-1:0] TX_LAST = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_LAST = RCW'(RX_DEPTH);

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_WAIT = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_ACK  = 1'b1;

  logic [MW-1:0]  tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp;
  logic [TAW-1:0] tx_rp;
  logic [TCW-1:0] tx_cnt;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_empty;
  logic [MW-1:0]  tx_head;
  logic [1:0]     t_state;

  logic [MW-1:0]  rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp;
  logic [RAW-1:0] rx_rp;
  logic [RCW-1:0] rx_cnt;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic [MW-1:0]  rx_head;
  logic [0:0]     r_state;

  logic           ack_q;
  logic           ack_qq;

  assign TX_FULL  = (tx_cnt == TX_LAST);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = TX_WR_EN & ~TX_FULL;
  assign tx_pop   = (t_state == T_REQ) & node.ACK_TX;
  assign tx_head  = tx_mem[tx_rp];
  assign TX_BUSY  = (t_state != T_IDLE);

  always_ff @(posedge CLK) begin
    if (tx_push)
      tx_mem[tx_wp] <= {TX_WR_ADDR, TX_WR_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push)
        tx_wp <= tx_wp + 1'b1;
      if (tx_pop)
        tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // The head stays queued until the node latches it, so a push can
  // never overwrite the message currently on ADDR_IN/DATA_IN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      t_state      <= T_IDLE;
      node.REQ_TX  <= 1'b0;
      node.ADDR_IN <= '0;
      node.DATA_IN <= '0;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (!tx_empty) begin
            node.ADDR_IN <= tx_head[MW-1:DATA_WIDTH];
            node.DATA_IN <= tx_head[DATA_WIDTH-1:0];
            node.REQ_TX  <= 1'b1;
            t_state      <= T_REQ;
          end
        end
        T_REQ: begin
          if (node.ACK_TX) begin
            node.REQ_TX <= 1'b0;
            t_state     <= T_WAIT;
          end
        end
        T_WAIT: begin
          if (!node.ACK_TX)
            t_state <= T_IDLE;
        end
        default: begin
          node.REQ_TX <= 1'b0;
          t_state     <= T_IDLE;
        end
      endcase
    end
  end

  assign rx_full    = (rx_cnt == RX_LAST);
  assign RX_EMPTY   = (rx_cnt == '0);
  assign rx_push    = (r_state == R_IDLE) & node.REQ_RX & ~rx_full;
  assign rx_pop     = RX_RD_EN & ~RX_EMPTY;
  assign rx_head    = rx_mem[rx_rp];
  assign RX_RD_ADDR = rx_head[MW-1:DATA_WIDTH];
  assign RX_RD_DATA = rx_head[DATA_WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (rx_push)
      rx_mem[rx_wp] <= {node.ADDR_OUT, node.DATA_OUT};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push)
        rx_wp <= rx_wp + 1'b1;
      if (rx_pop)
        rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // A full queue simply withholds ACK_RX; the node keeps REQ_RX up.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= R_IDLE;
      node.ACK_RX <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rx_push) begin
            node.ACK_RX <= 1'b1;
            r_state     <= R_ACK;
          end
        end
        R_ACK: begin
          if (!node.REQ_RX) begin
            node.ACK_RX <= 1'b0;
            r_state     <= R_IDLE;
          end
        end
        default: begin
          node.ACK_RX <= 1'b0;
          r_state     <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_q   <= 1'b0;
      ack_qq  <= 1'b0;
      ACK_CNT <= '0;
    end else begin
      ack_q  <= node.ACK_RECEIVED;
      ack_qq <= ack_q;
      if (ack_q && !ack_qq)
        ACK_CNT <= ACK_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_ulpb_host_if.sv
// Randomized bench for ulpb_host_if: node-side handshake model plus
// queue-level reference of TX, RX and acknowledge counting.
module tb_ulpb_host_if;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } msg_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TX_WR_EN;
  logic [7:0]  TX_WR_ADDR;
  logic [31:0] TX_WR_DATA;
  logic        TX_FULL;
  logic        TX_BUSY;
  logic        RX_RD_EN;
  logic [7:0]  RX_RD_ADDR;
  logic [31:0] RX_RD_DATA;
  logic        RX_EMPTY;
  logic [7:0]  ACK_CNT;

  always #5 CLK = ~CLK;

  ulpb_host_if_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  ulpb_host_if #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TX_DEPTH(4),
    .RX_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .TX_WR_EN(TX_WR_EN),
    .TX_WR_ADDR(TX_WR_ADDR),
    .TX_WR_DATA(TX_WR_DATA),
    .TX_FULL(TX_FULL),
    .TX_BUSY(TX_BUSY),
    .RX_RD_EN(RX_RD_EN),
    .RX_RD_ADDR(RX_RD_ADDR),
    .RX_RD_DATA(RX_RD_DATA),
    .RX_EMPTY(RX_EMPTY),
    .ACK_CNT(ACK_CNT),
    .node(bus)
  );

  int   checks;
  int   errors;
  msg_t txq[$];
  msg_t rxq[$];
  msg_t rx_src[$];
  int   hist[$];
  int   exp_ack;
  bit   ack_prev;
  bit   tx_wr;
  msg_t tx_msg;
  bit   rd_en;
  bit   ntx_en;
  bit   nrx_en;
  bit   ack_lvl;
  int   nt;
  int   dly;
  int   hold;
  int   nr;
  int   rdly;
  msg_t rx_cur;
  int   tx_sent;
  int   dly_fix;
  int   hold_fix;
  int   rhold_fix;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    txq.delete();
    rxq.delete();
    rx_src.delete();
    hist.delete();
    exp_ack  = 0;
    ack_prev = 0;
    ack_lvl  = 0;
    nt       = 0;
    nr       = 0;
    tx_wr    = 0;
    rd_en    = 0;
    tx_sent  = 0;
  endtask

  task automatic do_reset();
    RESET            = 1'b1;
    TX_WR_EN         = 1'b0;
    RX_RD_EN         = 1'b0;
    bus.ACK_TX       = 1'b0;
    bus.REQ_RX       = 1'b0;
    bus.ACK_RECEIVED = 1'b0;
    bus.ADDR_OUT     = '0;
    bus.DATA_OUT     = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model();
  endtask

  // One clock of the node model, host stimulus and queue reference.
  task automatic cyc();
    bit acc_tx;
    bit pop_tx;
    bit acc_rx;
    bit pop_rx;
    bit prev_ack;
    acc_tx     = tx_wr && (txq.size() < 4);
    pop_tx     = 0;
    TX_WR_EN   = tx_wr;
    TX_WR_ADDR = tx_msg.a;
    TX_WR_DATA = tx_msg.d;
    case (nt)
      0: begin
        if (bus.REQ_TX) begin
          nt  = 1;
          dly = (dly_fix >= 0) ? dly_fix : $urandom_range(0, 3);
        end
      end
      1: begin
        chk("tx_req_hold", bus.REQ_TX, 1);
        if (txq.size() > 0) begin
          chk("tx_addr", bus.ADDR_IN, txq[0].a);
          chk("tx_data", bus.DATA_IN, txq[0].d);
        end else
          chk("tx_spurious_req", bus.REQ_TX, 0);
        if (ntx_en) begin
          if (dly == 0) begin
            bus.ACK_TX = 1'b1;
            pop_tx     = 1;
            nt         = 2;
            hold = (hold_fix >= 0) ? hold_fix : $urandom_range(0, 2);
          end else
            dly--;
        end
      end
      2: begin
        if (hold == 0) begin
          bus.ACK_TX = 1'b0;
          nt         = 3;
        end else
          hold--;
      end
      default: ;
    endcase

    pop_rx   = rd_en && (rxq.size() > 0);
    RX_RD_EN = rd_en;
    if (pop_rx) begin
      chk("rx_addr", RX_RD_ADDR, rxq[0].a);
      chk("rx_data", RX_RD_DATA, rxq[0].d);
    end
    case (nr)
      0: begin
        if (nrx_en && rx_src.size() > 0) begin
          rx_cur       = rx_src.pop_front();
          bus.REQ_RX   = 1'b1;
          bus.ADDR_OUT = rx_cur.a;
          bus.DATA_OUT = rx_cur.d;
          nr           = 1;
        end else begin
          bus.ADDR_OUT = 8'($urandom);
          bus.DATA_OUT = $urandom;
        end
      end
      2: begin
        if (rdly == 0) begin
          bus.REQ_RX = 1'b0;
          nr         = 3;
        end else
          rdly--;
      end
      default: ;
    endcase
    acc_rx = (nr == 1) && (rxq.size() < 4);

    bus.ACK_RECEIVED = ack_lvl;
    if (ack_lvl && !ack_prev)
      exp_ack++;
    ack_prev = ack_lvl;
    prev_ack = bus.ACK_TX;

    @(posedge CLK);
    #1;

    if (pop_tx && txq.size() > 0) begin
      txq.delete(0);
      tx_sent++;
    end
    if (acc_tx)
      txq.push_back(tx_msg);
    if (prev_ack)
      chk("tx_req_drop", bus.REQ_TX, 0);
    if (nt == 3) begin
      chk("tx_gap", bus.REQ_TX, 0);
      nt = 0;
    end
    chk("tx_full", TX_FULL, txq.size() == 4);

    if (pop_rx)
      rxq.delete(0);
    if (acc_rx) begin
      rxq.push_back(rx_cur);
      chk("rx_ack_rise", bus.ACK_RX, 1);
      nr   = 2;
      rdly = (rhold_fix >= 0) ? rhold_fix : $urandom_range(0, 2);
    end else if (nr == 1)
      chk("rx_backpressure", bus.ACK_RX, 0);
    if (nr == 3) begin
      chk("rx_ack_fall", bus.ACK_RX, 0);
      nr = 0;
    end
    chk("rx_empty", RX_EMPTY, rxq.size() == 0);

    hist.push_back(exp_ack);
    if (hist.size() >= 2)
      chk("ack_cnt", ACK_CNT, hist[hist.size()-2] % 256);
    tx_wr = 0;
    rd_en = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((txq.size() > 0 || nt != 0 || rx_src.size() > 0 ||
            nr != 0 || rxq.size() > 0) && n < 300) begin
      rd_en = 1;
      cyc();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ntx_en     = 1;
    nrx_en     = 1;
    dly_fix    = -1;
    hold_fix   = -1;
    rhold_fix  = -1;
    tx_msg     = '0;
    TX_WR_ADDR = '0;
    TX_WR_DATA = '0;
    do_reset();

    chk("rst_req_tx", bus.REQ_TX, 0);
    chk("rst_ack_rx", bus.ACK_RX, 0);
    chk("rst_addr_in", bus.ADDR_IN, 0);
    chk("rst_data_in", bus.DATA_IN, 0);
    chk("rst_ack_cnt", ACK_CNT, 0);
    chk("rst_tx_full", TX_FULL, 0);
    chk("rst_rx_empty", RX_EMPTY, 1);
    chk("rst_tx_busy", TX_BUSY, 0);

    dly_fix  = 2;
    hold_fix = 3;
    tx_msg   = {8'hAB, 32'h12345678};
    tx_wr    = 1;
    cyc();
    chk("single_no_req_yet", bus.REQ_TX, 0);
    cyc();
    chk("single_req", bus.REQ_TX, 1);
    chk("single_addr", bus.ADDR_IN, 8'hAB);
    chk("single_data", bus.DATA_IN, 32'h12345678);
    chk("single_busy", TX_BUSY, 1);
    repeat (10) cyc();
    chk("single_sent", tx_sent, 1);
    chk("single_idle", TX_BUSY, 0);
    chk("single_hold_addr", bus.ADDR_IN, 8'hAB);

    dly_fix  = -1;
    hold_fix = -1;
    ntx_en   = 0;
    tx_sent  = 0;
    for (int i = 0; i < 5; i++) begin
      tx_msg = {8'h40 + 8'(i), $urandom};
      tx_wr  = 1;
      cyc();
    end
    chk("full_flag", TX_FULL, 1);
    ntx_en = 1;
    drain();
    chk("full_sent", tx_sent, 4);
    chk("full_clear", TX_FULL, 0);

    rhold_fix = -1;
    for (int i = 0; i < 5; i++)
      rx_src.push_back({8'h10 + 8'(i), 32'(i)});
    repeat (25) cyc();
    chk("rx_pend_ack", bus.ACK_RX, 0);
    chk("rx_pend_req", nr, 1);
    chk("rx_pend_head", RX_RD_ADDR, 8'h10);
    rd_en = 1;
    cyc();
    cyc();
    chk("rx_fifth_ack", bus.ACK_RX, 1);
    drain();
    chk("rx_drained", RX_EMPTY, 1);

    dly_fix   = 1;
    hold_fix  = 1;
    rhold_fix = 1;
    rx_src.push_back({8'h77, 32'hCAFEF00D});
    rx_src.push_back({8'h78, 32'h0BADBEEF});
    tx_msg = {8'h55, 32'hA5A5A5A5};
    tx_wr  = 1;
    cyc();
    tx_msg = {8'h56, 32'h5A5A5A5A};
    tx_wr  = 1;
    cyc();
    drain();
    dly_fix   = -1;
    hold_fix  = -1;
    rhold_fix = -1;

    for (int i = 0; i < 600; i++) begin
      tx_wr  = ($urandom_range(0, 2) == 0);
      tx_msg = {8'($urandom), $urandom};
      rd_en  = $urandom_range(0, 1) == 1;
      if (rx_src.size() < 2 && $urandom_range(0, 3) == 0)
        rx_src.push_back({8'($urandom), $urandom});
      if ($urandom_range(0, 2) == 0)
        ack_lvl = ~ack_lvl;
      cyc();
    end
    ack_lvl = 0;
    drain();

    do_reset();
    ack_lvl = 1;
    cyc();
    chk("ack_lat1", ACK_CNT, 0);
    ack_lvl = 0;
    cyc();
    chk("ack_lat2", ACK_CNT, 1);
    for (int i = 0; i < 256; i++) begin
      ack_lvl = 1;
      cyc();
      ack_lvl = 0;
      cyc();
    end
    ack_lvl = 1;
    repeat (10) cyc();
    ack_lvl = 0;
    repeat (3) cyc();
    chk("ack_wrap", ACK_CNT, 2);

    do_reset();
    ntx_en    = 0;
    rhold_fix = 5;
    rx_src.push_back({8'h99, 32'h13572468});
    tx_msg  = {8'h3C, 32'h24681357};
    tx_wr   = 1;
    ack_lvl = 1;
    cyc();
    ack_lvl = 0;
    cyc();
    cyc();
    chk("mid_setup_req", bus.REQ_TX, 1);
    chk("mid_setup_ack", bus.ACK_RX, 1);
    chk("mid_setup_cnt", ACK_CNT, 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_req_tx", bus.REQ_TX, 0);
    chk("mid_ack_rx", bus.ACK_RX, 0);
    chk("mid_tx_full", TX_FULL, 0);
    chk("mid_rx_empty", RX_EMPTY, 1);
    chk("mid_ack_cnt", ACK_CNT, 0);
    chk("mid_tx_busy", TX_BUSY, 0);
    do_reset();
    ntx_en    = 1;
    rhold_fix = -1;

    tx_msg = {8'hE1, 32'hFEEDFACE};
    tx_wr  = 1;
    rx_src.push_back({8'hE2, 32'h00C0FFEE});
    cyc();
    drain();
    chk("post_rst_sent", tx_sent, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpb_host_if.md
# ulpb_host_if

Host-side companion to the ulpb bus node. It sits between a local word-oriented master (processor or layer controller) and the node's parallel message handshakes. Outbound messages are queued and presented to the node over the REQ_TX/ACK_TX handshake. Inbound messages are accepted over the REQ_RX/ACK_RX handshake into a receive queue, and bus-level acknowledges reported on ACK_RECEIVED are counted.

## Interface
Parameters:
- ADDR_WIDTH, 8, message address width; equals the node's ADDR_WIDTH.
- DATA_WIDTH, 32, message payload width; equals the node's DATA_WIDTH.
- TX_DEPTH, 4, TX queue entries; power of two, at least 2.
- RX_DEPTH, 4, RX queue entries; power of two, at least 2.

Ports:
- CLK  in  1  single clock, shared with the node.
- RESET  in  1  synchronous, active-high reset.
- TX_WR_EN  in  1  push {TX_WR_ADDR, TX_WR_DATA} into the TX queue.
- TX_WR_ADDR  in  ADDR_WIDTH  destination address.
- TX_WR_DATA  in  DATA_WIDTH  payload.
- TX_FULL  out  1  TX queue holds TX_DEPTH entries.
- TX_BUSY  out  1  TX FSM is not in T_IDLE.
- RX_RD_EN  in  1  pop the RX queue head.
- RX_RD_ADDR  out  ADDR_WIDTH  RX head address (show-ahead).
- RX_RD_DATA  out  DATA_WIDTH  RX head payload (show-ahead).
- RX_EMPTY  out  1  RX queue is empty.
- ACK_CNT  out  8  count of bus acknowledges; wraps modulo 256.
- ADDR_IN  out  ADDR_WIDTH  to node: address of the pending TX message.
- DATA_IN  out  DATA_WIDTH  to node: payload of the pending TX message.
- REQ_TX  out  1  to node: transmit request.
- ACK_TX  in  1  from node: arbitration won, message latched.
- ADDR_OUT  in  ADDR_WIDTH  from node: received address.
- DATA_OUT  in  DATA_WIDTH  from node: received payload.
- REQ_RX  in  1  from node: received message valid.
- ACK_RX  out  1  to node: received message taken.
- ACK_RECEIVED  in  1  from node: last TX was acknowledged (level).

## Operation
- Reset values:
  - REQ_TX=0, ACK_RX=0, ADDR_IN=0, DATA_IN=0, ACK_CNT=0.
  - Both queues empty: TX_FULL=0, RX_EMPTY=1, TX_BUSY=0.
  - RX_RD_ADDR/RX_RD_DATA are don't-care while RX_EMPTY=1.
  - Both FSMs enter their idle states.
- TX queue:
  - A push is accepted only when TX_FULL=0 (registered count). A push while full is discarded silently.
  - A push and a pop in the same cycle are both honoured when the queue is not full.
- TX FSM, states T_IDLE, T_REQ, T_WAIT:
  - T_IDLE: if the queue is not empty, register the head into ADDR_IN/DATA_IN, set REQ_TX=1, go to T_REQ.
  - T_REQ: hold REQ_TX and ADDR_IN/DATA_IN stable. When ACK_TX=1 is sampled: REQ_TX<=0, pop the head, go to T_WAIT.
  - T_WAIT: when ACK_TX=0 is sampled, go to T_IDLE. No new request is issued until ACK_TX has fallen.
  - ADDR_IN/DATA_IN hold their last values until the next load.
- RX queue / RX FSM, states R_IDLE, R_ACK:
  - R_IDLE: if REQ_RX=1 and the RX queue is not full, push {ADDR_OUT, DATA_OUT}, set ACK_RX=1, go to R_ACK.
  - R_IDLE while full: ACK_RX stays 0 and REQ_RX is left pending (backpressure). No message is lost and no overrun flag exists.
  - R_ACK: hold ACK_RX=1 until REQ_RX=0 is sampled, then ACK_RX<=0 and go to R_IDLE. Exactly one push per REQ_RX assertion.
  - RX_RD_EN while empty is ignored.
  - A pop and a blocked push in the same cycle: the pop happens and the push is retried next cycle.
- Acknowledge counter: register ACK_RECEIVED. Each 0->1 transition increments ACK_CNT by 1 (8-bit wrap, 255->0). Level-high periods count once.
- RESET asserted mid-handshake aborts immediately: REQ_TX and ACK_RX drop on the next edge and queue contents are lost.

## Timing
- TX_WR_EN into an empty idle queue at edge n: REQ_TX and ADDR_IN/DATA_IN are valid after edge n+1.
- ACK_TX sampled high at edge m: REQ_TX is low after edge m and TX_FULL may deassert after edge m.
- Back-to-back messages: the next REQ_TX rises no earlier than one edge after ACK_TX is sampled low.
- REQ_RX sampled high at edge k with space available: ACK_RX is high and RX_EMPTY=0 after edge k.
- ACK_RX falls one edge after REQ_RX is sampled low.
- The RX head is visible the same cycle RX_EMPTY falls. After a pop at edge j, the next entry is visible after edge j.
- ACK_CNT updates one edge after the ACK_RECEIVED rising edge is registered, i.e. 2 edges of latency.

## Test plan
- Single TX: push addr 0xAB, data 0x12345678; the node model raises ACK_TX 3 cycles after REQ_TX -> ADDR_IN=0xAB, DATA_IN=0x12345678 while REQ_TX=1; REQ_TX drops one edge after ACK_TX is sampled high; no second request while ACK_TX stays high.
- TX full: push 5 messages back-to-back with TX_DEPTH=4 and ACK_TX held low -> TX_FULL=1 after the 4th push; the 5th is dropped; with ACK_TX released, exactly 4 requests go out in push order.
- RX backpressure: node model issues 5 REQ_RX messages (addr 0x10+i, data i) with no reads -> 4 are acknowledged; the 5th REQ_RX stays pending with ACK_RX=0 until one RX_RD_EN, then it is accepted; reads return i=0..4 in order.
- Simultaneous TX and RX: REQ_TX handshake and REQ_RX handshake overlap in the same cycles -> both complete independently with correct data.
- ACK counter: pulse ACK_RECEIVED 257 times, plus one 10-cycle-long high -> ACK_CNT ends at 2 (the 258 rises wrap modulo 256).
- Reset mid-handshake: assert RESET while REQ_TX=1 and ACK_RX=1 -> both low after the next edge, TX_FULL=0, RX_EMPTY=1, ACK_CNT=0.
